// File: rtl/adc_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : adc_serial_rx
//  Description : WM8731 ADC receive stage. Generates b_clk and adc_lr_clk
//                from m_clk, deserialises adcdat into left/right samples and
//                presents each stereo pair on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_serial_rx #(
    parameter int BCLK_DIV   = 4,
    parameter int FRAME_BCLK = 64,
    parameter int SAMPLE_W   = 16
) (
    input  logic                m_clk,
    input  logic                reset,
    input  logic                en,
    input  logic                adcdat,
    output logic                b_clk,
    output logic                adc_lr_clk,
    output logic [SAMPLE_W-1:0] left_data,
    output logic [SAMPLE_W-1:0] right_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BCLK);
    localparam int PAIR_W = 2 * SAMPLE_W;

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(FRAME_BCLK - 1);
    localparam logic [BIT_W-1:0] C_BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] C_HALF     = BIT_W'(FRAME_BCLK / 2);
    localparam logic [BIT_W-1:0] C_CAP_LAST = BIT_W'(PAIR_W - 1);

    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_b_clk;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_lr_clk;
    logic [PAIR_W-1:0]   r_shift;
    logic                r_load_pend;
    logic [SAMPLE_W-1:0] r_left;
    logic [SAMPLE_W-1:0] r_right;
    logic                r_valid;
    logic                r_overrun;

    logic                w_tick;
    logic                w_fall;
    logic [BIT_W-1:0]    w_bit_next;
    logic                w_capture;
    logic                w_frame_done;

    // Divider terminal count; a tick with b_clk high is the b_clk fall event
    always_comb begin
        w_tick       = en && (r_div_cnt == C_DIV_LAST);
        w_fall       = w_tick && r_b_clk;
        w_bit_next   = (r_bit_cnt == C_BIT_LAST) ? '0 : (r_bit_cnt + C_BIT_ONE);
        w_capture    = w_fall && (r_bit_cnt <= C_CAP_LAST);
        w_frame_done = w_fall && (r_bit_cnt == C_CAP_LAST);
    end

    // Bit clock: toggles every BCLK_DIV m_clk edges, first toggle is a rise
    always_ff @(posedge m_clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_b_clk   <= 1'b0;
        end else if (!en) begin
            r_div_cnt <= '0;
            r_b_clk   <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_b_clk   <= ~r_b_clk;
        end else begin
            r_div_cnt <= r_div_cnt + C_DIV_ONE;
        end
    end

    // Frame position counter and frame clock, both advanced on b_clk falls
    always_ff @(posedge m_clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= C_BIT_LAST;
            r_lr_clk  <= 1'b0;
        end else if (!en) begin
            r_bit_cnt <= C_BIT_LAST;
            r_lr_clk  <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_next;
            r_lr_clk  <= (w_bit_next < C_HALF);
        end
    end

    // Mid-bit capture of adcdat, MSB first; flag the pair as complete
    always_ff @(posedge m_clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_load_pend <= 1'b0;
        end else if (!en) begin
            r_shift     <= '0;
            r_load_pend <= 1'b0;
        end else begin
            r_load_pend <= w_frame_done;
            if (w_capture) begin
                r_shift <= {r_shift[PAIR_W-2:0], adcdat};
            end
        end
    end

    // Output registers and handshake; a load always wins over an accept
    always_ff @(posedge m_clk or posedge reset) begin
        if (reset) begin
            r_left    <= '0;
            r_right   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_load_pend) begin
            r_left  <= r_shift[PAIR_W-1:SAMPLE_W];
            r_right <= r_shift[SAMPLE_W-1:0];
            r_valid <= 1'b1;
            if (r_valid && !sample_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign b_clk        = r_b_clk;
    assign adc_lr_clk   = r_lr_clk;
    assign left_data    = r_left;
    assign right_data   = r_right;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_serial_rx
//  Description : Self-checking bench for adc_serial_rx. A frame-level model
//                predicts clocks, sample pairs and handshake state per edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_serial_rx;

    logic        m_clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        adcdat = 1'b0;
    logic        sample_ready = 1'b0;
    logic        b_clk;
    logic        adc_lr_clk;
    logic [15:0] left_data;
    logic [15:0] right_data;
    logic        sample_valid;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    // Reference model state: edges since enable, per-frame words, outputs
    int          ec = 0;
    logic [31:0] words [0:15];
    logic        m_valid = 1'b0;
    logic        m_ovr = 1'b0;
    logic [15:0] m_left = '0;
    logic [15:0] m_right = '0;

    adc_serial_rx #(
        .BCLK_DIV  (4),
        .FRAME_BCLK(64),
        .SAMPLE_W  (16)
    ) dut (
        .m_clk       (m_clk),
        .reset       (reset),
        .en          (en),
        .adcdat      (adcdat),
        .b_clk       (b_clk),
        .adc_lr_clk  (adc_lr_clk),
        .left_data   (left_data),
        .right_data  (right_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun)
    );

    // 12.5 MHz master clock
    always #40 m_clk = ~m_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s at ec=%0d: got=%h expected=%h", tag, ec, got, exp);
        end
    endtask

    task automatic check_all(input logic exp_b, input logic exp_lr);
        check("b_clk", {31'd0, b_clk}, {31'd0, exp_b});
        check("lr_clk", {31'd0, adc_lr_clk}, {31'd0, exp_lr});
        check("left", {16'd0, left_data}, {16'd0, m_left});
        check("right", {16'd0, right_data}, {16'd0, m_right});
        check("valid", {31'd0, sample_valid}, {31'd0, m_valid});
        check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    // One m_clk edge: codec drives data, model predicts, outputs compared
    task automatic step(input logic en_i, input logic rdy_i);
        int  nn;
        int  pre;
        int  m;
        bit  load;
        int  fidx;
        int  n;
        logic exp_b;
        logic exp_lr;
        en           = en_i;
        sample_ready = rdy_i;
        // codec updates adcdat only while b_clk is high (after its rise)
        if (en_i && (ec % 8) >= 4) begin
            nn  = ec / 8 + 1;
            pre = (nn - 2) % 64;
            m   = (nn - 2) / 64;
            if (nn >= 2 && pre < 32 && m < 16)
                adcdat = words[m][31 - pre];
            else
                adcdat = 1'($urandom);
        end
        @(posedge m_clk);
        load = 1'b0;
        fidx = 0;
        if (en_i) begin
            ec++;
            if (ec >= 265 && ((ec - 265) % 512) == 0) begin
                load = 1'b1;
                fidx = (ec - 265) / 512;
            end
        end else begin
            ec = 0;
        end
        if (load) begin
            if (m_valid && !rdy_i) m_ovr = 1'b1;
            m_left  = words[fidx][31:16];
            m_right = words[fidx][15:0];
            m_valid = 1'b1;
        end else if (m_valid && rdy_i) begin
            m_valid = 1'b0;
        end
        n      = ec / 8;
        exp_b  = en_i && ((ec % 8) >= 4);
        exp_lr = en_i && (n >= 1) && (((n - 1) % 64) < 32);
        #1;
        check_all(exp_b, exp_lr);
        @(negedge m_clk);
    endtask

    // Asynchronous reset pulse; outputs must clear before any clock edge
    task automatic pulse_reset();
        reset = 1'b1;
        en    = 1'b0;
        #1;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_left  = '0;
        m_right = '0;
        ec      = 0;
        check_all(1'b0, 1'b0);
        repeat (2) @(posedge m_clk);
        #1;
        check_all(1'b0, 1'b0);
        @(negedge m_clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        @(negedge m_clk);
        pulse_reset();

        // Single pair accepted at once, then two unaccepted pairs -> overrun
        words[0] = 32'hA5A5_3C3C;
        words[1] = 32'h1234_5678;
        words[2] = 32'h9ABC_DEF0;
        while (ec < 1400) step(1'b1, (ec < 300 || ec >= 1300));
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        check("left_last", {16'd0, left_data}, 32'h9ABC);
        check("right_last", {16'd0, right_data}, 32'hDEF0);

        // Reset mid-frame, then a load coinciding with an accept
        pulse_reset();
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        while (ec < 900) step(1'b1, (ec == 776));
        check("no_ovr_on_accept", {31'd0, overrun}, 32'd0);
        check("valid_kept", {31'd0, sample_valid}, 32'd1);

        // Disable at bit 10 of a frame, idle 100 cycles, re-enable
        while (ec < 1120) step(1'b1, 1'($urandom));
        for (int i = 0; i < 100; i++) step(1'b0, 1'($urandom));
        words[0] = 32'hFFFF_0001;
        words[1] = $urandom;
        while (ec < 270) step(1'b1, 1'b0);
        check("reen_left", {16'd0, left_data}, 32'hFFFF);
        check("reen_right", {16'd0, right_data}, 32'h0001);
        while (ec < 800) step(1'b1, 1'b1);

        // Randomised frames and backpressure
        pulse_reset();
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        while (ec < 2400) step(1'b1, ($urandom_range(0, 3) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
